// File: rtl/imu_spi_responder_if.sv
// SPI bus between an external mode-0 master and the IMU register responder.
// Signal names match the physical pins so board-level mapping stays obvious.
interface imu_spi_responder_if;
  logic spi_sclk;
  logic spi_ss;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_sclk,
    output spi_ss,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe
  );

  modport slave (
    input  spi_sclk,
    input  spi_ss,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe
  );
endinterface

// File: rtl/imu_spi_responder.sv
// SPI mode-0 slave exposing an IMU-style register map with sensor snapshots,
// a few R/W configuration registers and a write-commit side channel.
module imu_spi_responder #(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h71,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  imu_spi_responder_if.slave        spi,
  input  logic [47:0]               acc,
  input  logic [47:0]               gyr,
  input  logic [15:0]               temp,
  input  logic                      sample_valid,
  output logic [7:0]                pwr_mgmt_1,
  output logic                      soft_reset,
  output logic                      wr_strobe,
  output logic [6:0]                wr_addr,
  output logic [7:0]                wr_data
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT_SS_HIGH} state_e;

  localparam int                   NSENS      = 14;
  localparam logic [6:0]           SENS_BASE  = 7'h3B;
  localparam logic [6:0]           SENS_LAST  = 7'h48;
  localparam logic [7:0]           PWR1_RST   = 8'h01;
  localparam int                   SETTLE_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [SETTLE_W-1:0]  SETTLE_MAX = SETTLE_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_prev_q;
  logic [SETTLE_W-1:0]    settle_q;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall, settled;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;

  logic [7:0]  cfg_q [0:4];
  logic [7:0]  int_en_q, user_ctrl_q, pwr1_q, pwr2_q;
  logic        soft_reset_q, wr_strobe_q;
  logic [6:0]  wr_addr_q;
  logic [7:0]  wr_data_q;

  logic [7:0]          byte_in;
  logic [6:0]          rd_addr;
  logic [7:0]          rd_data;
  logic                commit, take_snap;
  logic [8*NSENS-1:0]  sensor_in;
  logic [8*NSENS-1:0]  snap_flat;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign settled   = (settle_q == SETTLE_MAX);

  // Presets make an idle bus look deselected until real pin values arrive.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      settle_q    <= '0;
    end else begin
      sclk_sync_q <= SYNC_STAGES'({sclk_sync_q, spi.spi_sclk});
      ss_sync_q   <= SYNC_STAGES'({ss_sync_q, spi.spi_ss});
      mosi_sync_q <= SYNC_STAGES'({mosi_sync_q, spi.spi_mosi});
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      if (!settled) settle_q <= settle_q + SETTLE_W'(1);
    end
  end

  assign byte_in = {rx_q, mosi_s};
  assign rd_addr = (state_q == ADDR) ? byte_in[6:0] : addr_q + 7'd1;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    commit    = 1'b0;
    take_snap = 1'b0;
    case (state_q)
      IDLE: begin
        if (settled) begin
          if (ss_fall) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            rx_d      = 7'd0;
            tx_d      = 8'h00;
            take_snap = 1'b1;
          end else if (!ss_s) begin
            state_d = WAIT_SS_HIGH;
          end
        end
      end
      ADDR, DATA: begin
        if (sclk_rise) begin
          rx_d      = byte_in[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == ADDR) begin
              rw_d    = byte_in[7];
              addr_d  = byte_in[6:0];
              state_d = DATA;
              tx_d    = byte_in[7] ? rd_data : 8'h00;
            end else begin
              addr_d = addr_q + 7'd1;
              commit = ~rw_q;
              tx_d   = rw_q ? rd_data : 8'h00;
            end
          end
        // The fall right after a byte boundary must keep the freshly loaded MSB.
        end else if (sclk_fall && bit_cnt_q != 3'd0) begin
          tx_d = {tx_q[6:0], 1'b0};
        end
      end
      WAIT_SS_HIGH: ;
      default: state_d = IDLE;
    endcase
    if (ss_rise) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      rx_d      = 7'd0;
      tx_d      = 8'h00;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr >= 7'h19 && rd_addr <= 7'h1D) begin
      rd_data = cfg_q[3'(rd_addr - 7'h19)];
    end else if (rd_addr >= SENS_BASE && rd_addr <= SENS_LAST) begin
      rd_data = snap_flat[{4'(rd_addr - SENS_BASE), 3'b000} +: 8];
    end else begin
      case (rd_addr)
        7'h38:   rd_data = int_en_q;
        7'h6A:   rd_data = user_ctrl_q;
        7'h6B:   rd_data = pwr1_q;
        7'h6C:   rd_data = pwr2_q;
        7'h75:   rd_data = WHO_AM_I_VAL;
        default: rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      rx_q         <= 7'd0;
      tx_q         <= 8'h00;
      rw_q         <= 1'b0;
      addr_q       <= 7'd0;
      soft_reset_q <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= 7'd0;
      wr_data_q    <= 8'h00;
      for (int i = 0; i < 5; i++) cfg_q[i] <= 8'h00;
      int_en_q     <= 8'h00;
      user_ctrl_q  <= 8'h00;
      pwr1_q       <= PWR1_RST;
      pwr2_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      soft_reset_q <= 1'b0;
      wr_strobe_q  <= commit;
      if (commit) begin
        wr_addr_q <= addr_q;
        wr_data_q <= byte_in;
        if (addr_q == 7'h6B && byte_in[7]) begin
          for (int i = 0; i < 5; i++) cfg_q[i] <= 8'h00;
          int_en_q     <= 8'h00;
          user_ctrl_q  <= 8'h00;
          pwr1_q       <= PWR1_RST;
          pwr2_q       <= 8'h00;
          soft_reset_q <= 1'b1;
        end else if (addr_q >= 7'h19 && addr_q <= 7'h1D) begin
          cfg_q[3'(addr_q - 7'h19)] <= byte_in;
        end else begin
          case (addr_q)
            7'h38:   int_en_q    <= byte_in;
            7'h6A:   user_ctrl_q <= byte_in;
            7'h6B:   pwr1_q      <= {1'b0, byte_in[6:0]};
            7'h6C:   pwr2_q      <= byte_in;
            default: ;
          endcase
        end
      end
    end
  end

  // Byte gi of the sensor window corresponds to address SENS_BASE + gi.
  assign sensor_in = {acc, temp, gyr};

  for (genvar gi = 0; gi < NSENS; gi++) begin : g_sens
    logic [7:0] live_q, snap_q;
    always_ff @(posedge clk) begin
      if (!rst) begin
        live_q <= 8'h00;
        snap_q <= 8'h00;
      end else begin
        if (sample_valid) live_q <= sensor_in[8*(NSENS-1-gi) +: 8];
        if (take_snap)    snap_q <= live_q;
      end
    end
    assign snap_flat[8*gi +: 8] = snap_q;
  end

  assign spi.spi_miso    = ~ss_s & tx_q[7];
  assign spi.spi_miso_oe = ~ss_s;
  assign pwr_mgmt_1      = pwr1_q;
  assign soft_reset      = soft_reset_q;
  assign wr_strobe       = wr_strobe_q;
  assign wr_addr         = wr_addr_q;
  assign wr_data         = wr_data_q;

endmodule
